// File: rtl/util_tx_timestamp_pkg.sv
// Shared definitions for the TX timestamp gate: FSM states and header sizing.
package util_tx_timestamp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS,
    ST_HDR,
    ST_WAIT,
    ST_STREAM
  } state_t;

  // Number of FIFO beats that make up the 64-bit timestamp header.
  function automatic int unsigned hdr_beats(input int unsigned data_width);
    return 64 / data_width;
  endfunction

endpackage

// File: rtl/util_tx_timestamp_hdr.sv
// Timestamp header assembler: collects HDR_BEATS FIFO beats (low word first)
// into a 64-bit timestamp and exposes the full value on the completing beat.
module util_tx_timestamp_hdr
  import util_tx_timestamp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  beat,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  done,
  output logic [63:0]           ts_full,
  output logic [63:0]           ts_q
);

  localparam int unsigned HDR_BEATS = hdr_beats(DATA_WIDTH);

  logic cnt_q;

  assign done = beat && (cnt_q == 1'(HDR_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 1'b0;
    end else if (clear) begin
      cnt_q <= 1'b0;
    end else if (beat) begin
      cnt_q <= done ? 1'b0 : cnt_q + 1'b1;
    end
  end

  if (HDR_BEATS == 1) begin : g_single
    assign ts_full = 64'(data);
  end else begin : g_dual
    logic [DATA_WIDTH-1:0] lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lo_q <= '0;
      end else if (beat && !done) begin
        lo_q <= data;
      end
    end

    // Full value is combinational so the lateness compare sees it on the final beat.
    assign ts_full = {data, lo_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else if (done) begin
      ts_q <= ts_full;
    end
  end

endmodule

// File: rtl/util_tx_timestamp_gate.sv
// TX timestamp gate: strips the block header, holds the DAC stream at zero until
// the slot counter reaches the timestamp, then releases timestamp_every beats.
module util_tx_timestamp_gate
  import util_tx_timestamp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [31:0]           timestamp_every,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  dac_valid,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  dac_data_valid,
  output logic [63:0]           sample_count,
  output logic                  sync_out,
  output logic                  late,
  output logic                  underflow
);

  state_t      state_q, state_d;
  logic [31:0] every_q, every_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        hdr_beat, hdr_done;
  logic [63:0] ts_full, ts_q;
  logic        data_beat, block_end, late_d, underflow_d;

  util_tx_timestamp_hdr #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hdr (
    .clk    (clk),
    .rst_n  (resetn),
    .clear  (state_q != ST_HDR),
    .beat   (hdr_beat),
    .data   (s_data),
    .done   (hdr_done),
    .ts_full(ts_full),
    .ts_q   (ts_q)
  );

  assign sync_out = (state_q == ST_PASS) || (state_q == ST_STREAM);

  always_comb begin
    state_d     = state_q;
    every_d     = every_q;
    beat_cnt_d  = beat_cnt_q;
    s_ready     = 1'b0;
    hdr_beat    = 1'b0;
    data_beat   = 1'b0;
    block_end   = 1'b0;
    late_d      = 1'b0;
    underflow_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          every_d = timestamp_every;
          state_d = (timestamp_every == 32'd0) ? ST_PASS : ST_HDR;
        end
        ST_PASS: begin
          s_ready     = dac_valid & s_valid;
          data_beat   = s_ready;
          underflow_d = dac_valid & ~s_valid;
        end
        ST_HDR: begin
          s_ready  = s_valid;
          hdr_beat = s_valid;
          if (hdr_done) begin
            late_d  = ts_full < sample_count;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Compare uses the pre-increment count, so beat 0 lands on slot ts_q.
          if (dac_valid && (sample_count >= ts_q)) begin
            if (s_valid) begin
              s_ready    = 1'b1;
              data_beat  = 1'b1;
              beat_cnt_d = 32'd1;
              if (every_q == 32'd1) block_end = 1'b1;
              else                  state_d   = ST_STREAM;
            end else begin
              underflow_d = 1'b1;
            end
          end
        end
        ST_STREAM: begin
          s_ready     = dac_valid & s_valid;
          data_beat   = s_ready;
          underflow_d = dac_valid & ~s_valid;
          if (data_beat) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            if (beat_cnt_d == every_q) block_end = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (block_end) begin
        every_d = timestamp_every;
        state_d = (timestamp_every == 32'd0) ? ST_IDLE : ST_HDR;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      every_q        <= '0;
      beat_cnt_q     <= '0;
      sample_count   <= '0;
      dac_data       <= '0;
      dac_data_valid <= 1'b0;
      late           <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      state_q        <= state_d;
      every_q        <= every_d;
      beat_cnt_q     <= beat_cnt_d;
      sample_count   <= sample_count + 64'(dac_valid);
      dac_data_valid <= dac_valid;
      late           <= late_d;
      underflow      <= underflow_d;
      if (dac_valid) dac_data <= data_beat ? s_data : '0;
    end
  end

endmodule

// File: tb/tb_util_tx_timestamp_gate.sv
// Self-checking bench for util_tx_timestamp_gate (64-bit and 32-bit instances).
module tb_util_tx_timestamp_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        enable, s_valid, dac_valid, s_ready;
  logic [31:0] every;
  logic [63:0] s_data, dac_data, sample_count;
  logic        dac_data_valid, sync_out, late, underflow;

  logic        enable32, s_valid32, dac_valid32, s_ready32;
  logic [31:0] every32, s_data32, dac_data32;
  logic [63:0] sample_count32;
  logic        dac_data_valid32, sync_out32, late32, underflow32;

  int   checks = 0;
  int   failures = 0;
  logic rdy, rdy32;

  util_tx_timestamp_gate #(.DATA_WIDTH(64)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .timestamp_every(every),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dac_valid(dac_valid),
    .dac_data(dac_data), .dac_data_valid(dac_data_valid), .sample_count(sample_count),
    .sync_out(sync_out), .late(late), .underflow(underflow)
  );

  util_tx_timestamp_gate #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .resetn(resetn), .enable(enable32), .timestamp_every(every32),
    .s_data(s_data32), .s_valid(s_valid32), .s_ready(s_ready32), .dac_valid(dac_valid32),
    .dac_data(dac_data32), .dac_data_valid(dac_data_valid32), .sample_count(sample_count32),
    .sync_out(sync_out32), .late(late32), .underflow(underflow32)
  );

  typedef struct {
    logic        dv;
    logic        sv;
    logic [63:0] d;
    logic        rdy;
    logic [63:0] q;
    logic        qv;
    logic        uf;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic dv, input logic sv, input logic [63:0] d,
                              input logic r, input logic [63:0] q, input logic qv, input logic uf);
    vec_t v;
    v.dv = dv; v.sv = sv; v.d = d; v.rdy = r; v.q = q; v.qv = qv; v.uf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic dv, input logic sv, input logic [63:0] d);
    @(negedge clk);
    dac_valid = dv; s_valid = sv; s_data = d;
    #1 rdy = s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc32(input logic dv, input logic sv, input logic [31:0] d);
    @(negedge clk);
    dac_valid32 = dv; s_valid32 = sv; s_data32 = d;
    #1 rdy32 = s_ready32;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    enable = 1'b0; every = '0; dac_valid = 1'b0; s_valid = 1'b0; s_data = '0;
    enable32 = 1'b0; every32 = '0; dac_valid32 = 1'b0; s_valid32 = 1'b0; s_data32 = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Reference model for timed blocks: slot n carries word j of block k iff n = ts_k + j.
  longint unsigned blk_ts[8];
  int              nblk;
  int unsigned     ev;

  function automatic logic [63:0] word_of(input int k, input longint unsigned j);
    return 64'hD000_0000 + 64'(k) * 64'h100 + 64'(j);
  endfunction

  function automatic logic [63:0] exp_at(input longint unsigned slot);
    for (int k = 0; k < nblk; k++)
      if (slot >= blk_ts[k] && slot < blk_ts[k] + 64'(ev)) return word_of(k, slot - blk_ts[k]);
    return '0;
  endfunction

  function automatic logic streaming_after(input longint unsigned slot);
    for (int k = 0; k < nblk; k++)
      if (slot >= blk_ts[k] && slot + 1 < blk_ts[k] + 64'(ev)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic timed_run(input int unsigned dv_pct, input longint unsigned end_slot,
                           input int max_cyc);
    logic [63:0]     q[$];
    longint unsigned slot = 0;
    logic            sync_exp = 1'b0;
    logic            dv, sv;
    int              cycles = 0;
    for (int k = 0; k < nblk; k++) begin
      q.push_back(64'(blk_ts[k]));
      for (int unsigned j = 0; j < ev; j++) q.push_back(word_of(k, 64'(j)));
    end
    while (slot < end_slot && cycles < max_cyc) begin
      dv = ($urandom_range(99) < dv_pct);
      sv = (q.size() > 0);
      cyc(dv, sv, sv ? q[0] : 64'd0);
      cycles++;
      if (rdy) void'(q.pop_front());
      chk("ts_late", 64'(late), 64'd0);
      if (dv) begin
        chk("ts_data", dac_data, exp_at(slot));
        chk("ts_underflow", 64'(underflow), 64'd0);
        sync_exp = streaming_after(slot);
        slot++;
      end
      chk("ts_sync", 64'(sync_out), 64'(sync_exp));
      chk("ts_count", sample_count, slot);
    end
    chk("ts_slots_reached", slot, end_slot);
    chk("ts_fifo_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int unsigned     nslots;
    int unsigned     next_word, exp_word;
    logic            dv, sv;
    longint unsigned t;

    // Reset state
    do_reset();
    chk("rst_dac_data", dac_data, 64'd0);
    chk("rst_dac_data_valid", 64'(dac_data_valid), 64'd0);
    chk("rst_sample_count", sample_count, 64'd0);
    chk("rst_sync", 64'(sync_out), 64'd0);
    chk("rst_late", 64'(late), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_count32", sample_count32, 64'd0);

    // Pass-through table
    tbl[0]  = mk(1, 1, 64'd1, 1, 64'd1, 1, 0);
    tbl[1]  = mk(1, 1, 64'd2, 1, 64'd2, 1, 0);
    tbl[2]  = mk(0, 1, 64'd3, 0, 64'd2, 0, 0);
    tbl[3]  = mk(1, 1, 64'd3, 1, 64'd3, 1, 0);
    tbl[4]  = mk(1, 0, 64'd0, 0, 64'd0, 1, 1);
    tbl[5]  = mk(0, 0, 64'd0, 0, 64'd0, 0, 0);
    tbl[6]  = mk(1, 1, 64'd4, 1, 64'd4, 1, 0);
    tbl[7]  = mk(1, 1, 64'd5, 1, 64'd5, 1, 0);
    tbl[8]  = mk(0, 1, 64'd6, 0, 64'd5, 0, 0);
    tbl[9]  = mk(1, 1, 64'd6, 1, 64'd6, 1, 0);
    tbl[10] = mk(1, 1, 64'd7, 1, 64'd7, 1, 0);
    tbl[11] = mk(1, 1, 64'd8, 1, 64'd8, 1, 0);
    do_reset();
    every = 32'd0; enable = 1'b1;
    cyc(0, 0, 64'd0);
    nslots = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].dv, tbl[i].sv, tbl[i].d);
      if (tbl[i].dv) nslots++;
      chk($sformatf("pt_ready[%0d]", i), 64'(rdy), 64'(tbl[i].rdy));
      chk($sformatf("pt_data[%0d]", i), dac_data, tbl[i].q);
      chk($sformatf("pt_dvalid[%0d]", i), 64'(dac_data_valid), 64'(tbl[i].qv));
      chk($sformatf("pt_underflow[%0d]", i), 64'(underflow), 64'(tbl[i].uf));
      chk($sformatf("pt_sync[%0d]", i), 64'(sync_out), 64'd1);
      chk($sformatf("pt_late[%0d]", i), 64'(late), 64'd0);
    end
    chk("pt_count", sample_count, 64'(nslots));

    // Timed release: ts=20, four beats, dac_valid every cycle
    do_reset();
    every = 32'd4; enable = 1'b1;
    nblk = 1; ev = 4; blk_ts[0] = 20;
    timed_run(100, 30, 100);
    cyc(0, 1, 64'hEE);
    chk("tr_back_in_hdr_ready", 64'(rdy), 64'd1);

    // Late block: header ts=5 completes at sample_count=30
    do_reset();
    every = 32'd4; enable = 1'b1;
    for (int i = 0; i < 30; i++) cyc(1, 0, 64'd0);
    chk("late_hdr_no_underflow", 64'(underflow), 64'd0);
    chk("late_before", 64'(late), 64'd0);
    cyc(1, 1, 64'd5);
    chk("late_pulse", 64'(late), 64'd1);
    chk("late_hdr_out_zero", dac_data, 64'd0);
    cyc(1, 1, 64'hA);
    chk("late_pulse_once", 64'(late), 64'd0);
    chk("late_release_ready", 64'(rdy), 64'd1);
    chk("late_release_data", dac_data, 64'hA);
    cyc(1, 1, 64'hB);
    chk("late_data_b", dac_data, 64'hB);

    // Underflow inside a block
    do_reset();
    every = 32'd4; enable = 1'b1;
    cyc(1, 1, 64'd3);
    cyc(1, 0, 64'd0);
    cyc(1, 0, 64'd0);
    chk("uf_wait_not_due", 64'(underflow), 64'd0);
    cyc(1, 1, 64'hA);
    chk("uf_data_a", dac_data, 64'hA);
    cyc(1, 1, 64'hB);
    chk("uf_data_b", dac_data, 64'hB);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 64'd0);
      chk($sformatf("uf_pulse[%0d]", i), 64'(underflow), 64'd1);
      chk($sformatf("uf_zero[%0d]", i), dac_data, 64'd0);
    end
    cyc(1, 1, 64'hC);
    chk("uf_data_c", dac_data, 64'hC);
    chk("uf_clear", 64'(underflow), 64'd0);
    chk("uf_sync_c", 64'(sync_out), 64'd1);
    cyc(1, 1, 64'hD);
    chk("uf_data_d", dac_data, 64'hD);
    chk("uf_sync_d", 64'(sync_out), 64'd0);
    cyc(0, 1, 64'hEE);
    chk("uf_hdr_ready", 64'(rdy), 64'd1);

    // Enable drop during WAIT, then re-enable as pass-through
    do_reset();
    every = 32'd4; enable = 1'b1;
    cyc(1, 1, 64'd100);
    for (int i = 0; i < 49; i++) cyc(1, 0, 64'd0);
    chk("en_count_50", sample_count, 64'd50);
    enable = 1'b0;
    cyc(1, 0, 64'd0);
    chk("en_count_51", sample_count, 64'd51);
    cyc(1, 1, 64'h7);
    chk("en_idle_ready", 64'(rdy), 64'd0);
    chk("en_idle_sync", 64'(sync_out), 64'd0);
    chk("en_count_52", sample_count, 64'd52);
    every = 32'd0; enable = 1'b1;
    cyc(1, 0, 64'd0);
    cyc(1, 1, 64'h55);
    chk("en_pass_ready", 64'(rdy), 64'd1);
    chk("en_pass_data", dac_data, 64'h55);
    chk("en_pass_sync", 64'(sync_out), 64'd1);

    // 32-bit header: low word 0x10, high word 0 -> release at slot 16
    do_reset();
    every32 = 32'd2; enable32 = 1'b1;
    cyc32(1, 1, 32'h10);
    cyc32(1, 1, 32'h0);
    chk("h32_no_late", 64'(late32), 64'd0);
    for (int s = 2; s <= 16; s++) begin
      cyc32(1, 1, 32'hCAFE);
      chk($sformatf("h32_ready_slot%0d", s), 64'(rdy32), 64'(s == 16));
      chk($sformatf("h32_data_slot%0d", s), 64'(dac_data32), (s == 16) ? 64'hCAFE : 64'd0);
    end
    cyc32(1, 1, 32'hBEEF);
    chk("h32_data_second", 64'(dac_data32), 64'hBEEF);
    chk("h32_sync_after", 64'(sync_out32), 64'd0);

    // Randomized pass-through with random strobes and FIFO gaps
    do_reset();
    every = 32'd0; enable = 1'b1;
    next_word = 1; exp_word = 1;
    for (int i = 0; i < 300; i++) begin
      dv = 1'($urandom_range(1));
      sv = ($urandom_range(3) != 0);
      cyc(dv, sv, 64'(next_word));
      if (rdy) next_word++;
      if (dv) begin
        if (sv) begin
          chk("rp_data", dac_data, 64'(exp_word));
          chk("rp_underflow", 64'(underflow), 64'd0);
          exp_word++;
        end else begin
          chk("rp_gap_data", dac_data, 64'd0);
          chk("rp_gap_underflow", 64'(underflow), 64'd1);
        end
      end else begin
        chk("rp_idle_dvalid", 64'(dac_data_valid), 64'd0);
        chk("rp_idle_underflow", 64'(underflow), 64'd0);
      end
    end
    chk("rp_consumed", 64'(next_word), 64'(exp_word));

    // Randomized timed blocks with random strobes
    do_reset();
    ev = $urandom_range(6, 2);
    every = ev; enable = 1'b1;
    nblk = 6;
    t = 10 + $urandom_range(5);
    for (int k = 0; k < nblk; k++) begin
      blk_ts[k] = t;
      t = t + ev + 3 + $urandom_range(8);
    end
    timed_run(60, blk_ts[nblk-1] + ev + 4, 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
